// File: rtl/cia_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cia_add_scheduler
// Description : Time-shares one WORD_W-bit carry-increment adder slice between
//               two requesters. A WORDS*WORD_W-bit addition is sequenced one
//               word per cycle, least significant word first, and the carry of
//               each word is chained into the next. Requests are granted
//               round-robin, and the result is held until it is consumed.
// Options     : define CIA_SCHED_OVF_EN to build the signed-overflow flag
//               (res_ovf). Without it, res_ovf is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cia_add_scheduler #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // requester side
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [WORDS*WORD_W-1:0]   req_a0,
    input  logic [WORDS*WORD_W-1:0]   req_b0,
    input  logic                      req_cin0,
    input  logic [WORDS*WORD_W-1:0]   req_a1,
    input  logic [WORDS*WORD_W-1:0]   req_b1,
    input  logic                      req_cin1,
    // shared adder slice
    output logic [WORD_W-1:0]         add_a,
    output logic [WORD_W-1:0]         add_b,
    output logic                      add_cin,
    input  logic [WORD_W-1:0]         add_sum,
    input  logic                      add_cout,
    // result side
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_id,
    output logic [WORDS*WORD_W-1:0]   res_data,
    output logic                      res_cout,
    output logic                      res_ovf,
    output logic                      busy
);

    localparam int c_OP_W  = WORDS * WORD_W;
    localparam int c_IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [c_IDX_W-1:0]  idx_q;
    logic [c_IDX_W-1:0]  idx_d;
    logic                carry_q;
    logic                ptr_q;
    logic [c_OP_W-1:0]   a_q;
    logic [c_OP_W-1:0]   b_q;
    logic                cin_q;
    logic [c_OP_W-1:0]   res_data_q;
    logic                res_id_q;
    logic                res_cout_q;
    logic                res_valid_q;
    logic                busy_q;

    logic                w_any_req;
    logic                w_gnt;
    logic                w_in_idle;
    logic                w_in_run;
    logic                w_last_word;
    logic [WORD_W-1:0]   w_word_a;
    logic [WORD_W-1:0]   w_word_b;
    logic [c_OP_W-1:0]   w_sel_a;
    logic [c_OP_W-1:0]   w_sel_b;
    logic                w_sel_cin;

    // Round-robin arbitration: the pointer side wins if it is asking,
    // otherwise the other side is taken.
    assign w_any_req = |req_valid;
    assign w_gnt     = req_valid[ptr_q] ? ptr_q : ~ptr_q;
    assign w_in_idle = (state_q == ST_IDLE);
    assign w_in_run  = (state_q == ST_RUN);

    // Accept pulse is only offered from IDLE so pending requests simply wait.
    assign req_ready = (w_in_idle && w_any_req) ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

    assign w_sel_a   = w_gnt ? req_a1   : req_a0;
    assign w_sel_b   = w_gnt ? req_b1   : req_b0;
    assign w_sel_cin = w_gnt ? req_cin1 : req_cin0;

    // Current word of the captured operands, presented to the slice in RUN only.
    assign w_word_a    = a_q[int'(idx_q)*WORD_W +: WORD_W];
    assign w_word_b    = b_q[int'(idx_q)*WORD_W +: WORD_W];
    assign w_last_word = (idx_q == c_LAST_IDX);
    assign idx_d       = idx_q + c_IDX_W'(1);

    assign add_a   = w_in_run ? w_word_a : '0;
    assign add_b   = w_in_run ? w_word_b : '0;
    assign add_cin = w_in_run & ((idx_q == '0) ? cin_q : carry_q);

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;
    assign busy      = busy_q;

`ifdef CIA_SCHED_OVF_EN
    logic res_ovf_q;
    assign res_ovf = res_ovf_q;
`else
    assign res_ovf = 1'b0;
`endif

    // Sequencer FSM: grant and capture, walk the words through the slice,
    // then hold the result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            ptr_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_cout_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CIA_SCHED_OVF_EN
            res_ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_any_req) begin
                        a_q        <= w_sel_a;
                        b_q        <= w_sel_b;
                        cin_q      <= w_sel_cin;
                        res_id_q   <= w_gnt;
                        ptr_q      <= ~w_gnt;
                        idx_q      <= '0;
                        carry_q    <= 1'b0;
                        res_data_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_data_q[int'(idx_q)*WORD_W +: WORD_W] <= add_sum;
                    carry_q <= add_cout;
                    idx_q   <= idx_d;
                    if (w_last_word) begin
                        res_cout_q  <= add_cout;
`ifdef CIA_SCHED_OVF_EN
                        // Operands agree in sign but the sum does not.
                        res_ovf_q   <= (a_q[c_OP_W-1] == b_q[c_OP_W-1]) &&
                                       (add_sum[WORD_W-1] != a_q[c_OP_W-1]);
`endif
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
